// File: rtl/vector_loader.sv
// Collects X/Y element pairs into two parallel vectors for a scalar-product
// stage; holds the filled vectors until acknowledged, then clears them.
module vector_loader #(
  parameter int SIZE_ARRAY = 256,
  parameter int SIZE_INT   = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [SIZE_INT-1:0]           in_x,
  input  logic [SIZE_INT-1:0]           in_y,
  input  logic                          in_last,
  output logic [SIZE_INT-1:0]           OX [SIZE_ARRAY],
  output logic [SIZE_INT-1:0]           OY [SIZE_ARRAY],
  output logic                          vec_valid,
  input  logic                          vec_ack,
  output logic [$clog2(SIZE_ARRAY+1)-1:0] count
);

  localparam int CW = $clog2(SIZE_ARRAY + 1);

  typedef enum logic [1:0] {
    LOAD,
    FULL,
    CLEAR
  } state_e;

  state_e              state_q, state_d;
  logic [SIZE_INT-1:0] ox_q [SIZE_ARRAY];
  logic [SIZE_INT-1:0] ox_d [SIZE_ARRAY];
  logic [SIZE_INT-1:0] oy_q [SIZE_ARRAY];
  logic [SIZE_INT-1:0] oy_d [SIZE_ARRAY];
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                ready_q;
  logic                valid_q;
  logic                accept;

  assign accept = in_valid && ready_q;

  always_comb begin
    state_d = state_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      LOAD: begin
        if (accept) begin
          // The pair count doubles as the write index.
          for (int i = 0; i < SIZE_ARRAY; i++) begin
            if (cnt_q == CW'(i)) begin
              ox_d[i] = in_x;
              oy_d[i] = in_y;
            end
          end
          if (cnt_q < CW'(SIZE_ARRAY))
            cnt_d = cnt_q + 1'b1;
          if (in_last || cnt_q == CW'(SIZE_ARRAY - 1))
            state_d = FULL;
        end
      end
      FULL: begin
        if (vec_ack) begin
          state_d = CLEAR;
          cnt_d   = '0;
          for (int i = 0; i < SIZE_ARRAY; i++) begin
            ox_d[i] = '0;
            oy_d[i] = '0;
          end
        end
      end
      CLEAR: begin
        state_d = LOAD;
        cnt_d   = '0;
        for (int i = 0; i < SIZE_ARRAY; i++) begin
          ox_d[i] = '0;
          oy_d[i] = '0;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      for (int i = 0; i < SIZE_ARRAY; i++) begin
        ox_q[i] <= '0;
        oy_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == LOAD);
      valid_q <= (state_d == FULL);
      for (int i = 0; i < SIZE_ARRAY; i++) begin
        ox_q[i] <= ox_d[i];
        oy_q[i] <= oy_d[i];
      end
    end
  end

  assign in_ready  = ready_q;
  assign vec_valid = valid_q;
  assign count     = cnt_q;
  assign OX        = ox_q;
  assign OY        = oy_q;

endmodule

// File: doc/vector_loader.md
VECTOR_LOADER -- requirements
Module: vector_loader

Interface
REQ-001 The block SHALL have parameter SIZE_ARRAY, default 256, giving the number of element pairs per vector.
REQ-002 The block SHALL have parameter SIZE_INT, default 32, giving the element width in bits.
REQ-003 The block SHALL use one clock; reset SHALL be synchronous and active-high.
REQ-004 Port clk, input, 1 bit: the single clock, rising edge.
REQ-005 Port rst, input, 1 bit: synchronous active-high reset.
REQ-006 Port in_valid, input, 1 bit: in_x, in_y and in_last are valid.
REQ-007 Port in_ready, output, 1 bit: the block accepts a pair this cycle.
REQ-008 Port in_x, input, SIZE_INT bits: X element.
REQ-009 Port in_y, input, SIZE_INT bits: Y element.
REQ-010 Port in_last, input, 1 bit: final pair of the current vector.
REQ-011 Port OX, output, SIZE_INT x SIZE_ARRAY (unpacked array): X vector for the downstream scalar-product stage.
REQ-012 Port OY, output, SIZE_INT x SIZE_ARRAY (unpacked array): Y vector for the downstream scalar-product stage.
REQ-013 Port vec_valid, output, 1 bit: OX and OY are complete and stable.
REQ-014 Port vec_ack, input, 1 bit: the downstream stage has consumed OX and OY.
REQ-015 Port count, output, $clog2(SIZE_ARRAY+1) bits: number of pairs loaded into the current vector.

Function
REQ-016 The block SHALL implement three states: LOAD, FULL and CLEAR.
REQ-017 in_ready SHALL be 1 only in LOAD; vec_valid SHALL be 1 only in FULL; both SHALL be registered outputs.
REQ-018 A beat SHALL be accepted on a rising edge where in_valid=1 and in_ready=1: OX[idx]<=in_x, OY[idx]<=in_y, idx<=idx+1, count<=count+1.
REQ-019 Fill order SHALL be ascending from index 0, and the first accepted pair SHALL land in OX[0]/OY[0].
REQ-020 On an accepted beat with in_last=1, or with idx==SIZE_ARRAY-1, the state SHALL go LOAD->FULL on that edge, so vec_valid rises the next cycle.
REQ-021 Entries not written before in_last (short vector) SHALL read 0, which leaves the downstream dot product unaffected.
REQ-022 In FULL, OX, OY and count SHALL hold constant, and in_x, in_y and in_valid SHALL be ignored.
REQ-023 In FULL with vec_ack=1, the state SHALL go to CLEAR on that edge; vec_ack outside FULL SHALL be ignored.
REQ-024 CLEAR SHALL last exactly one cycle: all OX/OY entries set to 0, idx=0, count=0, then go to LOAD.
REQ-025 Minimum cycles per vector SHALL be N accepted beats + 1 (FULL, with vec_ack held high) + 1 (CLEAR).
REQ-026 in_valid gaps in LOAD SHALL stall loading with no state change.
REQ-027 For SIZE_ARRAY=1, a single accepted beat SHALL move the state directly to FULL.
REQ-028 in_last on a beat that is not accepted SHALL have no effect.
REQ-029 No arithmetic SHALL be performed on data: elements SHALL pass through bit-exact; count SHALL saturate at SIZE_ARRAY and never wrap.

Reset
REQ-030 On the first rising edge with rst=1, the block SHALL set: state=LOAD, all OX/OY entries=0, idx=0, count=0, vec_valid=0, in_ready=1 from the next cycle.
REQ-031 rst SHALL take priority over every other input in any state.
REQ-032 Reset mid-load or in FULL SHALL discard the partial or complete vector without asserting vec_valid.

Verification (SIZE_ARRAY=4, SIZE_INT=8)
REQ-033 Full load: pairs (1,5),(2,6),(3,7),(4,8), back-to-back, in_last=0 -> vec_valid=1 the cycle after the 4th beat; OX={4,3,2,1}[3:0]; OY={8,7,6,5}[3:0]; count=4; in_ready=0.
REQ-034 Short vector: (9,2),(3,3) with in_last on the 2nd beat -> OX={0,0,3,9}, OY={0,0,3,2}, count=2, vec_valid=1.
REQ-035 Hold and ack: keep vec_ack=0 for 10 cycles while driving in_valid=1 with new data -> outputs unchanged; then vec_ack=1 for one cycle -> CLEAR cycle (all entries 0, count 0) -> in_ready=1 the following cycle.
REQ-036 Stall: in_valid toggled 1,0,0,1,1,0,1 -> exactly 4 pairs stored in order; FULL is reached only after the 4th accepted beat.
REQ-037 Reset mid-operation: rst=1 after 2 accepted beats -> next cycle count=0, all entries 0, vec_valid=0, in_ready=1; a following full load behaves as in REQ-033.
REQ-038 Stray ack: vec_ack=1 throughout LOAD -> no state change; vec_valid still asserts after the 4th beat, and CLEAR occurs on the first FULL cycle.
